dct_job_sequencer: RTL and testbench
====================================

Name: dct_job_sequencer

Overview:
- Bus-master controller that runs one complete DCT job on the avalon_dct peripheral without CPU involvement.
- Sequence per job:
  - program the Q format, then the size;
  - stream N samples from source memory into the peripheral;
  - poll each result until the peripheral reports it valid;
  - write the results to destination memory.
- Sits between the CPU control registers, a 1-cycle-latency data SRAM and the DCT peripheral's Avalon slave port.

Parameters:
MAX_SIZE, 256, largest legal job length; must equal the peripheral's MAX_SIZE
NBITS, 16, sample/result width
ADDR_W, 16, memory word-address width
TIMEOUT, 1024, max cycles to wait for dct_done on a single result read

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset (0 = reset)
start  in  1  1-cycle job launch; ignored while busy
abort  in  1  synchronous job cancel
src_base  in  ADDR_W  first source word address
dst_base  in  ADDR_W  first destination word address
length  in  9  number of samples N
q_m  in  NBITS  Q-format integer bits, forwarded to peripheral
busy  out  1  job in progress
done  out  1  1-cycle pulse at job end (any outcome)
status  out  2  0 OK, 1 bad length, 2 timeout, 3 aborted; valid from done until next start
mem_addr  out  ADDR_W  memory word address
mem_read  out  1  memory read strobe; mem_rdata valid exactly 1 cycle later
mem_write  out  1  memory write strobe
mem_wdata  out  NBITS  memory write data
mem_rdata  in  NBITS  memory read data
dct_address  out  8  peripheral register/result address
dct_read  out  1  peripheral read
dct_write  out  1  peripheral write
dct_writedata  out  NBITS  peripheral write data
dct_readdata  in  NBITS  peripheral read data
dct_done  in  1  peripheral ready; 0 stalls a read

Behaviour:
- Reset: state IDLE; counters k and timer 0; outputs as follows:
  - busy, done, mem_read, mem_write, dct_read, dct_write all 0;
  - status 0;
  - all address and data outputs 0.
- Strobes and addresses are registered. At most one of mem_read, mem_write, dct_read, dct_write is asserted per cycle.
- start in IDLE latches src_base, dst_base, length and q_m; busy rises on the next cycle.
- start with length<2 or length>MAX_SIZE:
  - no bus traffic;
  - done pulses 1 cycle after start;
  - status=1;
  - busy never rises.
- States and transitions:
  - IDLE: wait for start.
  - CFG_Q: dct_write=1, addr 2, data q_m; 1 cycle -> CFG_SIZE.
  - CFG_SIZE: dct_write=1, addr 0, data length; 1 cycle; k<=0 -> LD_RD.
  - LD_RD: mem_read=1, mem_addr=src_base+k; 1 cycle -> LD_WR.
  - LD_WR: dct_write=1, addr 1, dct_writedata=mem_rdata; k++. If k==length-1 then k<=0 -> UL_RD, else -> LD_RD. Load phase costs 2 cycles/sample.
  - UL_RD: dct_read=1, dct_address=k[7:0], held until dct_done=1 is sampled. On that cycle:
    - capture dct_readdata;
    - -> UL_WR.
  - UL_RD timeout: a timer counts cycles with dct_done=0. When the count reaches TIMEOUT, deassert dct_read, status=2 -> FIN.
  - UL_WR: mem_write=1, mem_addr=dst_base+k, mem_wdata=captured data; k++. If k==length-1 -> FIN, else -> UL_RD; the timer clears on every UL_RD entry.
  - FIN: done=1 for 1 cycle; busy=0 on the following cycle -> IDLE.
- Address arithmetic wraps modulo 2^ADDR_W. No error on wrap.
- abort while busy:
  - all strobes drop on the next cycle;
  - status=3;
  - done pulses; return to IDLE.
  - The peripheral is left as-is; the next job reprograms it.
- abort in IDLE: no effect.
- abort and timeout on the same cycle: abort wins (status=3).
- start and abort on the same cycle in IDLE: start is ignored.
- start while busy: ignored. Latched parameters do not change mid-job.
- Reset asserted mid-job: immediate return to reset values on the next edge. No done pulse.
- Cycle count for a good job with no stalls: 2 + 2N (load) + 2N (unload) + 1 (FIN). dct_done low adds cycles only in UL_RD.

Test Plan:
- Basic job: src_base=0x100 holding 1,2,3,4 (Q15 raw), dst_base=0x200, length=4, q_m=0.
  - Expected writes to DCT: addr2←0, addr0←4, then addr1←1,2,3,4.
  - 4 reads then 4 memory writes at 0x200..0x203 equal to a peripheral model.
  - done at cycle 19 after start; status=0.
- Stall handling: model holds dct_done=0 for 5 cycles on result index 2 → dct_read and dct_address=2 stay stable through the stall; job completes with status=0, 5 cycles late.
- Timeout: TIMEOUT=16 and dct_done stuck 0 on index 0 → dct_read drops after 16 cycles; done pulses with status=2; no memory writes occur.
- Bad length: length=1, then length=257 → each gives done 1 cycle after start, status=1, zero bus strobes, busy stays 0.
- Abort: abort asserted during LD_WR of sample 3 of 8 → strobes 0 next cycle, done pulse, status=3. A following job with length=2 runs correctly.
- Boundaries:
  - start asserted again while busy → no effect on the running job.
  - length=MAX_SIZE=256 → last DCT result address is 255 with no wrap.
  - src_base=0xFFFE, length=4 → reads 0xFFFE, 0xFFFF, 0x0000, 0x0001.

Source files
------------

// File: rtl/dct_job_sequencer.sv
// dct_job_sequencer: runs one DCT job on avalon_dct (configure, load N samples, poll and unload N results)
module dct_job_sequencer #(
  parameter int MAX_SIZE = 256,
  parameter int NBITS = 16,
  parameter int ADDR_W = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [8:0]        length,
  input  logic [NBITS-1:0]  q_m,
  output logic              busy,
  output logic              done,
  output logic [1:0]        status,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [NBITS-1:0]  mem_wdata,
  input  logic [NBITS-1:0]  mem_rdata,
  output logic [7:0]        dct_address,
  output logic              dct_read,
  output logic              dct_write,
  output logic [NBITS-1:0]  dct_writedata,
  input  logic [NBITS-1:0]  dct_readdata,
  input  logic              dct_done
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, CFG_Q, CFG_SIZE, LD_RD, LD_WR, UL_RD, UL_WR, FIN} state_t;
  state_t state_q, state_d;
  logic [8:0] k_q, k_d, len_q, len_d, kn;
  logic [TW-1:0] timer_q, timer_d, tn;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d, mem_addr_q, mem_addr_d;
  logic [NBITS-1:0] mem_wdata_q, mem_wdata_d, wdata_q, wdata_d;
  logic [7:0] dct_address_q, dct_address_d;
  logic [1:0] status_q, status_d;
  logic busy_q, busy_d, done_q, done_d;
  logic mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic dct_read_q, dct_read_d, dct_write_q, dct_write_d;
  logic last, bad_len;
  assign kn = k_q + 9'd1;
  assign tn = timer_q + TW'(1);
  assign last = k_q == len_q - 9'd1;
  assign bad_len = length < 9'd2 || 32'(length) > MAX_SIZE;
  // Outputs are registered from the next state, so each strobe is visible in the cycle its state is occupied.
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    timer_d = timer_q;
    src_d = src_q;
    dst_d = dst_q;
    len_d = len_q;
    status_d = status_q;
    done_d = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    dct_address_d = dct_address_q;
    wdata_d = wdata_q;
    mem_read_d = 1'b0;
    mem_write_d = 1'b0;
    dct_read_d = 1'b0;
    dct_write_d = 1'b0;
    if (abort && state_q != IDLE && state_q != FIN) begin
      state_d = FIN;
      status_d = 2'd3;
      done_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: if (start && !abort) begin
          src_d = src_base;
          dst_d = dst_base;
          len_d = length;
          status_d = bad_len ? 2'd1 : 2'd0;
          done_d = bad_len;
          if (!bad_len) begin
            state_d = CFG_Q;
            dct_write_d = 1'b1;
            dct_address_d = 8'd2;
            wdata_d = q_m;
          end
        end
        CFG_Q: begin
          state_d = CFG_SIZE;
          dct_write_d = 1'b1;
          dct_address_d = 8'd0;
          wdata_d = NBITS'(len_q);
        end
        CFG_SIZE: begin
          state_d = LD_RD;
          k_d = '0;
          mem_read_d = 1'b1;
          mem_addr_d = src_q;
        end
        LD_RD: begin
          state_d = LD_WR;
          dct_write_d = 1'b1;
          dct_address_d = 8'd1;
        end
        LD_WR: if (last) begin
          state_d = UL_RD;
          k_d = '0;
          timer_d = '0;
          dct_read_d = 1'b1;
          dct_address_d = 8'd0;
        end else begin
          state_d = LD_RD;
          k_d = kn;
          mem_read_d = 1'b1;
          mem_addr_d = src_q + ADDR_W'(kn);
        end
        UL_RD: if (dct_done) begin
          state_d = UL_WR;
          mem_write_d = 1'b1;
          mem_addr_d = dst_q + ADDR_W'(k_q);
          mem_wdata_d = dct_readdata;
        end else if (tn == TW'(TIMEOUT)) begin
          state_d = FIN;
          status_d = 2'd2;
          done_d = 1'b1;
        end else begin
          timer_d = tn;
          dct_read_d = 1'b1;
        end
        UL_WR: if (last) begin
          state_d = FIN;
          done_d = 1'b1;
        end else begin
          state_d = UL_RD;
          k_d = kn;
          timer_d = '0;
          dct_read_d = 1'b1;
          dct_address_d = kn[7:0];
        end
        FIN: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      k_q <= '0;
      timer_q <= '0;
      src_q <= '0;
      dst_q <= '0;
      len_q <= '0;
      status_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
      dct_address_q <= '0;
      wdata_q <= '0;
      mem_read_q <= 1'b0;
      mem_write_q <= 1'b0;
      dct_read_q <= 1'b0;
      dct_write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      timer_q <= timer_d;
      src_q <= src_d;
      dst_q <= dst_d;
      len_q <= len_d;
      status_q <= status_d;
      busy_q <= busy_d;
      done_q <= done_d;
      mem_addr_q <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      dct_address_q <= dct_address_d;
      wdata_q <= wdata_d;
      mem_read_q <= mem_read_d;
      mem_write_q <= mem_write_d;
      dct_read_q <= dct_read_d;
      dct_write_q <= dct_write_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign status = status_q;
  assign mem_addr = mem_addr_q;
  assign mem_read = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_wdata = mem_wdata_q;
  assign dct_address = dct_address_q;
  assign dct_read = dct_read_q;
  assign dct_write = dct_write_q;
  // SRAM data only arrives in the LD_WR cycle, so it is forwarded straight to the peripheral.
  assign dct_writedata = state_q == LD_WR ? mem_rdata : wdata_q;
endmodule

// File: tb/tb_dct_job_sequencer.sv
// tb_dct_job_sequencer: directed jobs checked against a transaction-level job model
module tb_dct_job_sequencer;
  localparam int TO = 16;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, abort = 1'b0;
  logic [15:0] src_base = '0, dst_base = '0, q_m = '0;
  logic [8:0] length = '0;
  logic busy, done, mem_read, mem_write, dct_read, dct_write, dct_done;
  logic [1:0] status;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, dct_writedata, dct_readdata;
  logic [7:0] dct_address;
  int n_chk = 0, n_fail = 0;
  logic [15:0] smem [0:65535];
  logic [15:0] dmem [0:65535];
  logic [15:0] pv [0:255];
  int n_pv = 0, stall_cnt = 0, stall_from = 0, stall_idx = -1, stall_len = 0;
  logic [23:0] q_dw[$];
  logic [15:0] q_mr[$];
  logic [7:0] q_rd[$];
  logic [31:0] q_mw[$];
  logic [15:0] rd_log[$];
  int c_dw = 0, c_mr = 0, c_rd = 0, c_mw = 0, last_rd = -1;

  dct_job_sequencer #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .src_base(src_base), .dst_base(dst_base), .length(length), .q_m(q_m),
    .busy(busy), .done(done), .status(status),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dct_address(dct_address), .dct_read(dct_read), .dct_write(dct_write),
    .dct_writedata(dct_writedata), .dct_readdata(dct_readdata), .dct_done(dct_done)
  );

  always #5 clk = ~clk;

  // Peripheral stand-in: result i is the (N-1-i)th loaded sample XOR {i,i}; stalls a chosen index.
  always_comb begin
    int idx;
    idx = n_pv - 1 - int'(dct_address);
    dct_readdata = (idx >= 0 && idx < 256) ? pv[idx[7:0]] ^ {dct_address, dct_address} : 16'hDEAD;
  end
  assign dct_done = !(dct_read && int'(dct_address) == stall_idx && stall_cnt - stall_from < stall_len);

  always @(posedge clk) begin
    if (mem_read) mem_rdata <= smem[mem_addr];
    if (mem_write) dmem[mem_addr] <= mem_wdata;
    if (dct_write && dct_address == 8'd0) n_pv <= 0;
    if (dct_write && dct_address == 8'd1) begin
      pv[n_pv[7:0]] <= dct_writedata;
      n_pv <= n_pv + 1;
    end
    if (dct_read && !dct_done) stall_cnt <= stall_cnt + 1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Compare process: every bus strobe must match the next expected transaction.
  initial forever begin
    logic [63:0] e;
    @(negedge clk);
    if (reset) begin
      if (mem_read | mem_write | dct_read | dct_write)
        chk("strobe_count", 64'($countones({mem_read, mem_write, dct_read, dct_write})), 64'd1);
      if (dct_write) begin
        c_dw++;
        e = q_dw.size() > 0 ? {40'd0, q_dw.pop_front()} : '1;
        chk("dct_write", {40'd0, dct_address, dct_writedata}, e);
      end
      if (mem_read) begin
        c_mr++;
        rd_log.push_back(mem_addr);
        e = q_mr.size() > 0 ? {48'd0, q_mr.pop_front()} : '1;
        chk("mem_read", {48'd0, mem_addr}, e);
      end
      if (dct_read) begin
        c_rd++;
        last_rd = int'(dct_address);
        e = q_rd.size() > 0 ? {56'd0, q_rd.pop_front()} : '1;
        chk("dct_read", {56'd0, dct_address}, e);
      end
      if (mem_write) begin
        c_mw++;
        e = q_mw.size() > 0 ? {32'd0, q_mw.pop_front()} : '1;
        chk("mem_write", {32'd0, mem_addr, mem_wdata}, e);
      end
    end
  end

  task automatic fill(input logic [15:0] a, input int n);
    for (int i = 0; i < n; i++) begin
      logic [15:0] x;
      x = a + 16'(i);
      smem[x] = 16'($urandom);
    end
  endtask

  // Builds the job's expected transactions from a cycle timeline, then drives start and watches done.
  task automatic run_job(input logic [15:0] s, input logic [15:0] d, input int n, input logic [15:0] q,
                         input int sidx, input int slen, input int ab, input int rs,
                         output int got, output logic [1:0] st);
    int t, cut, ed, b_dw, b_mr, b_rd, b_mw, n_dw, n_mr, n_rd, n_mw;
    logic [1:0] es;
    logic [15:0] a;
    logic [7:0] i8;
    bit bad;
    bad = n < 2 || n > 256;
    cut = ab > 0 ? ab : 1 << 30;
    n_dw = 0; n_mr = 0; n_rd = 0; n_mw = 0;
    q_dw.delete(); q_mr.delete(); q_rd.delete(); q_mw.delete(); rd_log.delete();
    ed = 1;
    es = 2'd1;
    if (!bad) begin
      if (cut >= 1) begin q_dw.push_back({8'd2, q}); n_dw++; end
      if (cut >= 2) begin q_dw.push_back({8'd0, 16'(n)}); n_dw++; end
      for (int i = 0; i < n; i++) begin
        a = s + 16'(i);
        if (3 + 2 * i <= cut) begin q_mr.push_back(a); n_mr++; end
        if (4 + 2 * i <= cut) begin q_dw.push_back({8'd1, smem[a]}); n_dw++; end
      end
      t = 3 + 2 * n;
      es = 2'd0;
      for (int i = 0; i < n; i++) begin
        int sl;
        sl = i == sidx ? slen : 0;
        i8 = 8'(i);
        for (int r = 0; r < (sl >= TO ? TO : sl + 1); r++)
          if (t + r <= cut) begin q_rd.push_back(i8); n_rd++; end
        if (sl >= TO) begin
          t += TO;
          es = 2'd2;
          break;
        end
        if (t + sl + 1 <= cut) begin
          q_mw.push_back({d + 16'(i), smem[s + 16'(n - 1 - i)] ^ {i8, i8}});
          n_mw++;
        end
        t += sl + 2;
      end
      ed = t;
      if (ab > 0 && ab < t) begin
        ed = ab + 1;
        es = 2'd3;
      end
    end
    b_dw = c_dw; b_mr = c_mr; b_rd = c_rd; b_mw = c_mw;
    stall_from = stall_cnt;
    stall_idx = sidx;
    stall_len = slen;
    src_base = s; dst_base = d; length = 9'(n); q_m = q; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    src_base = ~s; dst_base = ~d; length = 9'(n + 1); q_m = ~q;
    got = 0;
    st = 2'd0;
    for (int c = 1; c <= ed + 8 && got == 0; c++) begin
      @(negedge clk);
      if (c == ab) abort = 1'b1;
      if (c == rs) start = 1'b1;
      chk("busy", {63'd0, busy}, {63'd0, !bad && c <= ed});
      if (done) begin
        got = c;
        st = status;
      end
      @(posedge clk);
      #1 abort = 1'b0;
      start = 1'b0;
    end
    chk("done_cycle", 64'(got), 64'(ed));
    chk("status", {62'd0, st}, {62'd0, es});
    @(negedge clk);
    chk("done_after", {63'd0, done}, 64'd0);
    chk("busy_after", {63'd0, busy}, 64'd0);
    chk("status_hold", {62'd0, status}, {62'd0, es});
    chk("n_dct_write", 64'(c_dw - b_dw), 64'(n_dw));
    chk("n_mem_read", 64'(c_mr - b_mr), 64'(n_mr));
    chk("n_dct_read", 64'(c_rd - b_rd), 64'(n_rd));
    chk("n_mem_write", 64'(c_mw - b_mw), 64'(n_mw));
  endtask

  initial begin
    int got;
    logic [1:0] st;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {busy, done, status, mem_addr, mem_read, mem_write, mem_wdata,
                          dct_address, dct_read, dct_write, dct_writedata}, 64'd0);
    reset = 1'b1;
    smem[16'h0100] = 16'd1;
    smem[16'h0101] = 16'd2;
    smem[16'h0102] = 16'd3;
    smem[16'h0103] = 16'd4;
    run_job(16'h0100, 16'h0200, 4, 16'h0000, -1, 0, 0, 0, got, st);
    chk("basic_done_19", 64'(got), 64'd19);
    chk("basic_status_ok", {62'd0, st}, 64'd0);
    chk("basic_res0", {48'd0, dmem[16'h0200]}, 64'h0004);
    chk("basic_res1", {48'd0, dmem[16'h0201]}, 64'h0102);
    chk("basic_res2", {48'd0, dmem[16'h0202]}, 64'h0200);
    chk("basic_res3", {48'd0, dmem[16'h0203]}, 64'h0302);
    fill(16'h0300, 4);
    run_job(16'h0300, 16'h0400, 4, 16'h0003, 2, 5, 0, 0, got, st);
    chk("stall_done_24", 64'(got), 64'd24);
    chk("stall_status_ok", {62'd0, st}, 64'd0);
    run_job(16'h0300, 16'h0500, 4, 16'h0001, 0, 1000, 0, 0, got, st);
    chk("timeout_done_27", 64'(got), 64'd27);
    chk("timeout_status", {62'd0, st}, 64'd2);
    run_job(16'h0300, 16'h0600, 1, 16'h0001, -1, 0, 0, 0, got, st);
    chk("len1_done_1", 64'(got), 64'd1);
    chk("len1_status", {62'd0, st}, 64'd1);
    run_job(16'h0300, 16'h0600, 257, 16'h0001, -1, 0, 0, 0, got, st);
    chk("len257_done_1", 64'(got), 64'd1);
    chk("len257_status", {62'd0, st}, 64'd1);
    fill(16'h0600, 8);
    run_job(16'h0600, 16'h0700, 8, 16'h0002, -1, 0, 8, 0, got, st);
    chk("abort_done_9", 64'(got), 64'd9);
    chk("abort_status", {62'd0, st}, 64'd3);
    run_job(16'h0600, 16'h0710, 2, 16'h0005, -1, 0, 0, 0, got, st);
    chk("after_abort_done_11", 64'(got), 64'd11);
    run_job(16'h0100, 16'h0220, 4, 16'h0000, -1, 0, 0, 6, got, st);
    chk("restart_done_19", 64'(got), 64'd19);
    chk("restart_res3", {48'd0, dmem[16'h0223]}, 64'h0302);
    fill(16'h1000, 256);
    run_job(16'h1000, 16'h2000, 256, 16'h0004, -1, 0, 0, 0, got, st);
    chk("max_done_1027", 64'(got), 64'd1027);
    chk("max_last_addr", 64'(last_rd), 64'd255);
    fill(16'hFFFE, 4);
    run_job(16'hFFFE, 16'h3000, 4, 16'h0000, -1, 0, 0, 0, got, st);
    chk("wrap_nreads", 64'(rd_log.size()), 64'd4);
    if (rd_log.size() == 4) begin
      chk("wrap_rd0", {48'd0, rd_log[0]}, 64'hFFFE);
      chk("wrap_rd1", {48'd0, rd_log[1]}, 64'hFFFF);
      chk("wrap_rd2", {48'd0, rd_log[2]}, 64'h0000);
      chk("wrap_rd3", {48'd0, rd_log[3]}, 64'h0001);
    end
    q_dw.delete(); q_mr.delete(); q_rd.delete(); q_mw.delete();
    q_dw.push_back({8'd2, 16'h0007});
    q_dw.push_back({8'd0, 16'd8});
    q_mr.push_back(16'h0600);
    q_dw.push_back({8'd1, smem[16'h0600]});
    src_base = 16'h0600; dst_base = 16'h0800; length = 9'd8; q_m = 16'h0007; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midreset_outputs", {busy, done, status, mem_addr, mem_read, mem_write, mem_wdata,
                             dct_address, dct_read, dct_write, dct_writedata}, 64'd0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midreset_no_done", {63'd0, done | busy}, 64'd0);
    end
    chk("midreset_queues", 64'(q_dw.size() + q_mr.size() + q_rd.size() + q_mw.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
